// File: rtl/avalon_pwm_pkg.sv
// Shared constants for the multi-channel Avalon-MM PWM: register map,
// STATUS/CTRL bit positions and the byte-lane mask helper.
package avalon_pwm_pkg;

  localparam logic [4:0] ADDR_CTRL   = 5'd0;
  localparam logic [4:0] ADDR_PERIOD = 5'd1;
  localparam logic [4:0] ADDR_POL    = 5'd2;
  localparam logic [4:0] ADDR_STATUS = 5'd3;
  localparam logic [4:0] ADDR_DUTY0  = 5'd4;

  localparam int STATUS_WRAP_BIT = 0;
  localparam int STATUS_PEND_BIT = 1;
  localparam int CTRL_IRQ_EN_BIT = 31;

  // Expands the four byteenable bits into a 32-bit write mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) m[8*b +: 8] = 8'hFF;
    end
    return m;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: active duty register loaded from its shadow at period
// boundaries, compare against the shared counter, polarity, output flop.
module pwm_channel #(
  parameter int          CNT_W    = 32,
  parameter int unsigned RST_DUTY = 250000
) (
  input  logic             csi_clk,
  input  logic             rsi_rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] duty_sh,
  input  logic [CNT_W-1:0] cnt,
  input  logic             idle,
  input  logic             en,
  input  logic             pol,
  output logic             pwm_out
);

  logic [CNT_W-1:0] duty_act_q, duty_act_d;
  logic             pwm_q, pwm_d;

  // NOTE: every always_comb output gets a value on every path (defaults
  // first), otherwise synthesis infers a latch.
  always_comb begin
    duty_act_d = duty_act_q;
    if (load) duty_act_d = duty_sh;
    // duty >= period is naturally 100% since cnt never reaches the period.
    pwm_d = (en & ~idle & (cnt < duty_act_q)) ^ pol;
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge csi_clk or negedge rsi_rst_n) begin
    if (!rsi_rst_n) begin
      duty_act_q <= CNT_W'(RST_DUTY);
      pwm_q      <= 1'b0;
    end else begin
      duty_act_q <= duty_act_d;
      pwm_q      <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/avalon_pwm_multi.sv
// Multi-channel PWM with Avalon-MM slave: bus decode, shadow registers,
// shared period counter, sticky wrap status/irq and registered readback.
module avalon_pwm_multi
  import avalon_pwm_pkg::*;
#(
  parameter int          NUM_CH     = 4,
  parameter int          CNT_W      = 32,
  parameter int unsigned RST_PERIOD = 500000,
  parameter int unsigned RST_DUTY   = 250000
) (
  input  logic              csi_clk,
  input  logic              rsi_rst_n,
  input  logic              avs_s0_chipselect,
  input  logic              avs_s0_read,
  input  logic              avs_s0_write,
  input  logic [4:0]        avs_s0_address,
  input  logic [3:0]        avs_s0_byteenable,
  input  logic [31:0]       avs_s0_writedata,
  output logic [31:0]       avs_s0_readdata,
  output logic              ins_irq,
  output logic [NUM_CH-1:0] coe_pwm_out
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [NUM_CH-1:0] en_q, en_d, pol_q, pol_d;
  logic              irq_en_q, irq_en_d;
  logic              wrap_flag_q, wrap_flag_d;
  logic              pending_q, pending_d;
  logic [CNT_W-1:0]  period_sh_q, period_sh_d;
  logic [CNT_W-1:0]  period_act_q, period_act_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  duty_sh_q [NUM_CH];
  logic [CNT_W-1:0]  duty_sh_d [NUM_CH];
  logic [31:0]       readdata_q, readdata_d;

  logic        wr_en, rd_en, idle, wrap, load, shadow_wr, wrap_clr;
  logic [31:0] wr_mask, ctrl_rd, status_rd, rd_mux;

  assign wr_en   = avs_s0_chipselect & avs_s0_write;
  assign rd_en   = avs_s0_chipselect & avs_s0_read;
  assign wr_mask = lane_mask(avs_s0_byteenable);

  // Idle counter reloads actives every cycle so writes commit right away.
  assign idle = (en_q == '0) || (period_act_q == '0);
  assign wrap = ~idle && (cnt_q == period_act_q - ONE);
  assign load = idle | wrap;

  always_comb begin
    ctrl_rd                  = '0;
    ctrl_rd[NUM_CH-1:0]      = en_q;
    ctrl_rd[CTRL_IRQ_EN_BIT] = irq_en_q;
    status_rd                  = '0;
    status_rd[STATUS_WRAP_BIT] = wrap_flag_q;
    status_rd[STATUS_PEND_BIT] = pending_q;
  end

  always_comb begin
    en_d        = en_q;
    pol_d       = pol_q;
    irq_en_d    = irq_en_q;
    period_sh_d = period_sh_q;
    duty_sh_d   = duty_sh_q;
    shadow_wr   = 1'b0;
    wrap_clr    = 1'b0;
    if (wr_en) begin
      case (avs_s0_address)
        ADDR_CTRL: begin
          en_d = (en_q & ~wr_mask[NUM_CH-1:0])
               | (avs_s0_writedata[NUM_CH-1:0] & wr_mask[NUM_CH-1:0]);
          if (wr_mask[CTRL_IRQ_EN_BIT]) irq_en_d = avs_s0_writedata[CTRL_IRQ_EN_BIT];
        end
        ADDR_PERIOD: begin
          period_sh_d = CNT_W'((32'(period_sh_q) & ~wr_mask) | (avs_s0_writedata & wr_mask));
          shadow_wr   = 1'b1;
        end
        ADDR_POL: begin
          pol_d = (pol_q & ~wr_mask[NUM_CH-1:0])
                | (avs_s0_writedata[NUM_CH-1:0] & wr_mask[NUM_CH-1:0]);
        end
        ADDR_STATUS: begin
          wrap_clr = wr_mask[STATUS_WRAP_BIT] & avs_s0_writedata[STATUS_WRAP_BIT];
        end
        default: begin
          for (int n = 0; n < NUM_CH; n++) begin
            if (avs_s0_address == ADDR_DUTY0 + 5'(n)) begin
              duty_sh_d[n] = CNT_W'((32'(duty_sh_q[n]) & ~wr_mask)
                                    | (avs_s0_writedata & wr_mask));
              shadow_wr    = 1'b1;
            end
          end
        end
      endcase
    end

    // A shadow write coinciding with a load stays pending for the next one.
    pending_d    = (pending_q & ~load) | shadow_wr;
    wrap_flag_d  = (wrap_flag_q & ~wrap_clr) | wrap;
    period_act_d = load ? period_sh_q : period_act_q;
    cnt_d        = load ? '0 : cnt_q + ONE;
  end

  always_comb begin
    rd_mux = '0;
    case (avs_s0_address)
      ADDR_CTRL:   rd_mux = ctrl_rd;
      ADDR_PERIOD: rd_mux = 32'(period_sh_q);
      ADDR_POL:    rd_mux = 32'(pol_q);
      ADDR_STATUS: rd_mux = status_rd;
      default: begin
        for (int n = 0; n < NUM_CH; n++) begin
          if (avs_s0_address == ADDR_DUTY0 + 5'(n)) rd_mux = 32'(duty_sh_q[n]);
        end
      end
    endcase
    readdata_d = rd_en ? rd_mux : readdata_q;
  end

  always_ff @(posedge csi_clk or negedge rsi_rst_n) begin
    if (!rsi_rst_n) begin
      en_q         <= '0;
      pol_q        <= '0;
      irq_en_q     <= 1'b0;
      wrap_flag_q  <= 1'b0;
      pending_q    <= 1'b0;
      period_sh_q  <= CNT_W'(RST_PERIOD);
      period_act_q <= CNT_W'(RST_PERIOD);
      cnt_q        <= '0;
      readdata_q   <= '0;
      // NOTE: the duty shadow array is a handful of registers with defined
      // reset values, not a RAM, so it is reset like any other flop.
      for (int n = 0; n < NUM_CH; n++) duty_sh_q[n] <= CNT_W'(RST_DUTY);
    end else begin
      en_q         <= en_d;
      pol_q        <= pol_d;
      irq_en_q     <= irq_en_d;
      wrap_flag_q  <= wrap_flag_d;
      pending_q    <= pending_d;
      period_sh_q  <= period_sh_d;
      period_act_q <= period_act_d;
      cnt_q        <= cnt_d;
      readdata_q   <= readdata_d;
      duty_sh_q    <= duty_sh_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_channel #(
      .CNT_W    (CNT_W),
      .RST_DUTY (RST_DUTY)
    ) u_ch (
      .csi_clk   (csi_clk),
      .rsi_rst_n (rsi_rst_n),
      .load      (load),
      .duty_sh   (duty_sh_q[g]),
      .cnt       (cnt_q),
      .idle      (idle),
      .en        (en_q[g]),
      .pol       (pol_q[g]),
      .pwm_out   (coe_pwm_out[g])
    );
  end

  assign avs_s0_readdata = readdata_q;
  assign ins_irq         = wrap_flag_q & irq_en_q;

endmodule

// File: tb/tb_avalon_pwm_multi.sv
// Directed bench for avalon_pwm_multi: register table, PWM waveform,
// shadow commit timing, wrap/irq corner cases and async reset.
module tb_avalon_pwm_multi;

  logic        clk, rst_n;
  logic        cs, rd, wr;
  logic [4:0]  addr;
  logic [3:0]  be;
  logic [31:0] wdata, rdata;
  logic        irq;
  logic [3:0]  pwm;

  int checks = 0;
  int errors = 0;

  avalon_pwm_multi dut (
    .csi_clk           (clk),
    .rsi_rst_n         (rst_n),
    .avs_s0_chipselect (cs),
    .avs_s0_read       (rd),
    .avs_s0_write      (wr),
    .avs_s0_address    (addr),
    .avs_s0_byteenable (be),
    .avs_s0_writedata  (wdata),
    .avs_s0_readdata   (rdata),
    .ins_irq           (irq),
    .coe_pwm_out       (pwm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        do_wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Bus tasks start and end on a falling edge; the access lands on the
  // rising edge in between.
  task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d; be = b;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; be = 4'h0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    d = rdata;
  endtask

  initial begin
    logic [31:0] r;
    logic [19:0] got, exp;
    logic        found;

    vecs[0]  = '{"ctrl_rst",    1'b0, 5'd0,  32'h0,        4'h0, 32'h0};
    vecs[1]  = '{"period_rst",  1'b0, 5'd1,  32'h0,        4'h0, 32'd500000};
    vecs[2]  = '{"pol_rst",     1'b0, 5'd2,  32'h0,        4'h0, 32'h0};
    vecs[3]  = '{"status_rst",  1'b0, 5'd3,  32'h0,        4'h0, 32'h0};
    vecs[4]  = '{"duty0_rst",   1'b0, 5'd4,  32'h0,        4'h0, 32'd250000};
    vecs[5]  = '{"duty1_rst",   1'b0, 5'd5,  32'h0,        4'h0, 32'd250000};
    vecs[6]  = '{"duty2_rst",   1'b0, 5'd6,  32'h0,        4'h0, 32'd250000};
    vecs[7]  = '{"duty3_rst",   1'b0, 5'd7,  32'h0,        4'h0, 32'd250000};
    vecs[8]  = '{"unmapped8",   1'b0, 5'd8,  32'h0,        4'h0, 32'h0};
    vecs[9]  = '{"unmapped_wr", 1'b1, 5'd20, 32'hFFFFFFFF, 4'hF, 32'h0};
    vecs[10] = '{"pol_rw",      1'b1, 5'd2,  32'hFFFFFFF5, 4'hF, 32'h5};
    vecs[11] = '{"pol_clr",     1'b1, 5'd2,  32'h0,        4'hF, 32'h0};
    vecs[12] = '{"ctrl_irqen",  1'b1, 5'd0,  32'hFFFFFFF0, 4'h8, 32'h80000000};
    vecs[13] = '{"ctrl_clr",    1'b1, 5'd0,  32'h0,        4'hF, 32'h0};
    vecs[14] = '{"duty0_full",  1'b1, 5'd4,  32'h00001234, 4'hF, 32'h00001234};
    vecs[15] = '{"duty0_be",    1'b1, 5'd4,  32'h000000FF, 4'h1, 32'h000012FF};
    vecs[16] = '{"period_wr",   1'b1, 5'd1,  32'd10,       4'hF, 32'd10};
    vecs[17] = '{"duty0_wr",    1'b1, 5'd4,  32'd3,        4'hF, 32'd3};

    rst_n = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0;
    addr = '0; be = '0; wdata = '0;
    #1;
    check("rst_pwm", 32'(pwm), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      if (vecs[i].do_wr) bus_write(vecs[i].addr, vecs[i].wdata, vecs[i].be);
      bus_read(vecs[i].addr, r);
      check(vecs[i].name, r, vecs[i].exp);
    end
    check("idle_pwm", 32'(pwm), 32'h0);

    // P=10, D=3: 3 high / 7 low, first high on the second edge after the write.
    bus_write(5'd0, 32'h1, 4'hF);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      got[i] = pwm[0];
      exp[i] = ((i % 10) < 3);
    end
    check("pattern_d3", 32'(got), 32'(exp));

    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (pwm[0]) found = 1'b1;
    end
    check("align_rise", 32'(found), 32'h1);

    // Now cnt==1. Change duty mid-period; it applies only after the wrap.
    bus_write(5'd4, 32'd6, 4'hF);
    bus_read(5'd3, r);
    check("status_pending", r, 32'h3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      got[i] = pwm[0];
      exp[i] = (((3 + i) % 10) < ((i >= 7) ? 6 : 3));
    end
    check("pattern_d6", 32'(got), 32'(exp));

    bus_read(5'd3, r);
    check("status_committed", r, 32'h1);
    @(negedge clk);
    check("rdata_hold", rdata, 32'h1);
    bus_write(5'd3, 32'h1, 4'h1);
    bus_read(5'd3, r);
    check("status_w1c", r, 32'h0);

    // cnt==7 here; wrap edge is the third from now.
    bus_write(5'd0, 32'h80000001, 4'hF);
    check("irq_before_wrap0", 32'(irq), 32'h0);
    @(negedge clk);
    check("irq_before_wrap1", 32'(irq), 32'h0);
    @(negedge clk);
    check("irq_on_wrap", 32'(irq), 32'h1);
    repeat (9) @(negedge clk);
    bus_write(5'd3, 32'h1, 4'h1);
    check("irq_w1c_vs_wrap", 32'(irq), 32'h1);
    bus_read(5'd3, r);
    check("status_set_wins", r, 32'h1);
    bus_write(5'd3, 32'h1, 4'h1);
    check("irq_cleared", 32'(irq), 32'h0);

    // ch1 duty 0 inverted -> 1, ch2 duty 20 > P -> 1, ch0/ch3 disabled -> 0.
    bus_write(5'd5, 32'd0, 4'hF);
    bus_write(5'd6, 32'd20, 4'hF);
    bus_write(5'd2, 32'h2, 4'hF);
    bus_write(5'd0, 32'h6, 4'hF);
    repeat (12) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("chan_mix%0d", i), 32'(pwm), 32'h6);
    end

    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pwm", 32'(pwm), 32'h0);
    check("async_rst_irq", 32'(irq), 32'h0);
    check("async_rst_rdata", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_read(5'd1, r);
    check("post_rst_period", r, 32'd500000);
    bus_read(5'd0, r);
    check("post_rst_ctrl", r, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
